// File: rtl/fft_sdf_delay_stage.sv
// Delay line and controller for one radix-2 DIF single-path delay-feedback FFT stage.
// Optional macro SDF_SCALE_EN: halve butterfly sum/diff with round-half-up.
module fft_sdf_delay_stage #(
    parameter int bit_width   = 16,
    parameter int delay_depth = 8,
    parameter int addr_w      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic [bit_width-1:0] Re_in,
    input  logic [bit_width-1:0] Im_in,
    output logic                 bf_en,
    output logic [bit_width-1:0] bf_Re_a,
    output logic [bit_width-1:0] bf_Im_a,
    output logic [bit_width-1:0] bf_Re_b,
    output logic [bit_width-1:0] bf_Im_b,
    input  logic [bit_width-1:0] bf_Re_sum,
    input  logic [bit_width-1:0] bf_Im_sum,
    input  logic [bit_width-1:0] bf_Re_diff,
    input  logic [bit_width-1:0] bf_Im_diff,
    output logic                 out_valid,
    output logic [bit_width-1:0] Re_out,
    output logic [bit_width-1:0] Im_out,
    output logic [addr_w-1:0]    tw_idx
);

    typedef enum logic {FILL, BFLY} phase_t;

    localparam logic [addr_w-1:0] last_ptr = addr_w'(delay_depth - 1);

    phase_t               phase, phase_nxt;
    logic [addr_w-1:0]    ptr, ptr_nxt;
    logic                 primed, primed_nxt;
    logic                 adv;
    logic [bit_width-1:0] in_re, in_im;
    logic [bit_width-1:0] rd_re, rd_im;
    logic [bit_width-1:0] hold_re_a, hold_im_a, hold_re_b, hold_im_b;
    logic [bit_width-1:0] sum_re, sum_im, diff_re, diff_im;
    logic [bit_width-1:0] ram_re [delay_depth];
    logic [bit_width-1:0] ram_im [delay_depth];

`ifdef SDF_SCALE_EN
    // Rebuild the true (W+1)-bit adder result from operand signs, then halve it.
    function automatic logic [bit_width-1:0] halve(
        input logic                 a_msb,
        input logic                 b_msb,
        input logic [bit_width-1:0] r,
        input logic                 sub
    );
        logic               same;
        logic               top;
        logic [bit_width:0] t;
        same = sub ? (a_msb != b_msb) : (a_msb == b_msb);
        top  = (same && (r[bit_width-1] != a_msb)) ? a_msb : r[bit_width-1];
        t    = {top, r} + (bit_width + 1)'(1);
        t    = {t[bit_width], t[bit_width:1]};
        return t[bit_width-1:0];
    endfunction

    assign sum_re  = halve(bf_Re_a[bit_width-1], bf_Re_b[bit_width-1], bf_Re_sum, 1'b0);
    assign sum_im  = halve(bf_Im_a[bit_width-1], bf_Im_b[bit_width-1], bf_Im_sum, 1'b0);
    assign diff_re = halve(bf_Re_a[bit_width-1], bf_Re_b[bit_width-1], bf_Re_diff, 1'b1);
    assign diff_im = halve(bf_Im_a[bit_width-1], bf_Im_b[bit_width-1], bf_Im_diff, 1'b1);
`else
    assign sum_re  = bf_Re_sum;
    assign sum_im  = bf_Im_sum;
    assign diff_re = bf_Re_diff;
    assign diff_im = bf_Im_diff;
`endif

    assign adv   = in_valid | (flush & primed & (phase == FILL));
    assign in_re = in_valid ? Re_in : '0;
    assign in_im = in_valid ? Im_in : '0;
    assign rd_re = ram_re[ptr];
    assign rd_im = ram_im[ptr];

    assign bf_en   = adv & (phase == BFLY);
    assign bf_Re_a = bf_en ? rd_re : hold_re_a;
    assign bf_Im_a = bf_en ? rd_im : hold_im_a;
    assign bf_Re_b = bf_en ? in_re : hold_re_b;
    assign bf_Im_b = bf_en ? in_im : hold_im_b;

    // Phase/pointer/primed next-state: step on every advance, toggle phase on wrap.
    always_comb begin
        phase_nxt  = phase;
        ptr_nxt    = ptr;
        primed_nxt = primed;
        if (adv) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == last_ptr) begin
                phase_nxt = (phase == FILL) ? BFLY : FILL;
                if (phase == FILL) primed_nxt = 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= FILL;
            ptr    <= '0;
            primed <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            ptr    <= ptr_nxt;
            primed <= primed_nxt;
        end
    end

    // Delay RAM: store input while filling, butterfly difference while pairing.
    always_ff @(posedge clk) begin
        if (adv) begin
            ram_re[ptr] <= (phase == BFLY) ? diff_re : in_re;
            ram_im[ptr] <= (phase == BFLY) ? diff_im : in_im;
        end
    end

    // Keep the adder operands stable when the butterfly is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_re_a <= '0;
            hold_im_a <= '0;
            hold_re_b <= '0;
            hold_im_b <= '0;
        end else if (bf_en) begin
            hold_re_a <= rd_re;
            hold_im_a <= rd_im;
            hold_re_b <= in_re;
            hold_im_b <= in_im;
        end
    end

    // Output register: sums while pairing, old delayed diffs while filling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Re_out    <= '0;
            Im_out    <= '0;
            tw_idx    <= '0;
        end else if (!adv) begin
            out_valid <= 1'b0;
        end else if (phase == BFLY) begin
            out_valid <= 1'b1;
            Re_out    <= sum_re;
            Im_out    <= sum_im;
            tw_idx    <= '0;
        end else if (primed) begin
            out_valid <= 1'b1;
            Re_out    <= rd_re;
            Im_out    <= rd_im;
            tw_idx    <= ptr;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_sdf_delay_stage.sv
// Testbench for fft_sdf_delay_stage (D=4) against an index-based SDF pairing model.
// Adder is modelled in the bench; SDF_SCALE_EN selects the halving expectation.
module tb_fft_sdf_delay_stage;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          flush;
    logic [W-1:0]  Re_in, Im_in;
    logic          bf_en;
    logic [W-1:0]  bf_Re_a, bf_Im_a, bf_Re_b, bf_Im_b;
    logic [W-1:0]  bf_Re_sum, bf_Im_sum, bf_Re_diff, bf_Im_diff;
    logic          out_valid;
    logic [W-1:0]  Re_out, Im_out;
    logic [AW-1:0] tw_idx;

    int tests;
    int fails;

    // Advance-indexed history since the last reset.
    int cnt;
    int xr [int];
    int xi [int];
    int dr [int];
    int di [int];

    fft_sdf_delay_stage #(.bit_width(W), .delay_depth(D), .addr_w(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
        .Re_in(Re_in), .Im_in(Im_in), .bf_en(bf_en),
        .bf_Re_a(bf_Re_a), .bf_Im_a(bf_Im_a),
        .bf_Re_b(bf_Re_b), .bf_Im_b(bf_Im_b),
        .bf_Re_sum(bf_Re_sum), .bf_Im_sum(bf_Im_sum),
        .bf_Re_diff(bf_Re_diff), .bf_Im_diff(bf_Im_diff),
        .out_valid(out_valid), .Re_out(Re_out), .Im_out(Im_out),
        .tw_idx(tw_idx)
    );

    assign bf_Re_sum  = bf_Re_a + bf_Re_b;
    assign bf_Im_sum  = bf_Im_a + bf_Im_b;
    assign bf_Re_diff = bf_Re_a - bf_Re_b;
    assign bf_Im_diff = bf_Im_a - bf_Im_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [W-1:0] w16(input int v);
        logic [31:0] t;
        t = v;
        return t[W-1:0];
    endfunction

    // Butterfly result as stored/emitted.
    function automatic logic [W-1:0] bfly(input int v);
`ifdef SDF_SCALE_EN
        return w16((v + 1) >>> 1);
`else
        return w16(v);
`endif
    endfunction

    task automatic do_reset();
        in_valid = 0;
        flush    = 0;
        Re_in    = '0;
        Im_in    = '0;
        rst_n    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cnt   = 0;
        xr.delete();
        xi.delete();
        dr.delete();
        di.delete();
    endtask

    // One clock of stimulus with model prediction and checks.
    task automatic step(input bit v, input bit f,
                        input logic [W-1:0] re, input logic [W-1:0] im);
        bit          h;
        bit          a;
        bit          ev;
        logic [W-1:0] er, ei;
        int          etw;
        in_valid = v;
        flush    = f;
        Re_in    = re;
        Im_in    = im;
        h  = ((cnt / D) % 2) == 1;
        a  = v || (f && cnt >= D && !h);
        ev = 0;
        er = '0;
        ei = '0;
        etw = 0;
        #1;
        tests++;
        if (bf_en !== (a && h)) begin
            fails++;
            $display("FAIL bf_en step %0d: got %b want %b", cnt, bf_en, a && h);
        end
        if (a && h) begin
            tests++;
            if (bf_Re_a !== w16(xr[cnt-D]) || bf_Im_a !== w16(xi[cnt-D]) ||
                bf_Re_b !== re || bf_Im_b !== im) begin
                fails++;
                $display("FAIL bf_operands step %0d: got a=%h/%h b=%h/%h want a=%h/%h b=%h/%h",
                         cnt, bf_Re_a, bf_Im_a, bf_Re_b, bf_Im_b,
                         w16(xr[cnt-D]), w16(xi[cnt-D]), re, im);
            end
        end
        if (a) begin
            xr[cnt] = v ? sx(re) : 0;
            xi[cnt] = v ? sx(im) : 0;
            if (h) begin
                ev = 1;
                er = bfly(xr[cnt-D] + xr[cnt]);
                ei = bfly(xi[cnt-D] + xi[cnt]);
                dr[cnt] = sx(bfly(xr[cnt-D] - xr[cnt]));
                di[cnt] = sx(bfly(xi[cnt-D] - xi[cnt]));
            end else if (cnt >= 2 * D) begin
                ev  = 1;
                er  = w16(dr[cnt-D]);
                ei  = w16(di[cnt-D]);
                etw = cnt % D;
            end
            cnt++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== ev) begin
            fails++;
            $display("FAIL out_valid step %0d: got %b want %b", cnt, out_valid, ev);
        end
        if (ev) begin
            tests++;
            if (Re_out !== er || Im_out !== ei || tw_idx !== AW'(etw)) begin
                fails++;
                $display("FAIL out_data step %0d: got %0d/%0d k=%0d want %0d/%0d k=%0d",
                         cnt, sx(Re_out), sx(Im_out), tw_idx, sx(er), sx(ei), etw);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        tests++;
        if (out_valid !== 1'b0 || Re_out !== '0 || Im_out !== '0 || tw_idx !== '0) begin
            fails++;
            $display("FAIL %s: got v=%b re=%h im=%h k=%0d want all 0",
                     tag, out_valid, Re_out, Im_out, tw_idx);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_zero_outputs("reset_state");
    endtask

    task automatic test_ramp_flush();
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 0, W'(i), '0);
        for (int i = 0; i < 4; i++) step(0, 1, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, '0);
        tests++;
        if (dr[4] != -4 || dr[7] != -4) begin
            fails++;
            $display("FAIL ramp_diff_model: got %0d,%0d want -4,-4", dr[4], dr[7]);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, W'(i), W'(i * 3));
            step(0, 0, '0, '0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, W'($urandom), W'($urandom));
        rst_n = 0;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk);
        #1;
        in_valid = 0;
        rst_n = 1;
        cnt   = 0;
        for (int i = 0; i < 4; i++) step(1, 0, W'($urandom), W'($urandom));
        for (int i = 0; i < 4; i++) step(1, 0, W'($urandom), W'($urandom));
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 16'h7fff, 16'h8000);
        tests++;
`ifdef SDF_SCALE_EN
        if (Re_out !== 16'h7fff) begin
`else
        if (Re_out !== 16'hfffe) begin
`endif
            fails++;
            $display("FAIL overflow_sum: got %h", Re_out);
        end
        for (int i = 0; i < 4; i++) step(0, 1, '0, '0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10 * D; i++) step(1, 0, W'($urandom), W'($urandom));
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 W'($urandom), W'($urandom));
        for (int i = 0; i < 2 * D; i++) step(0, 1, '0, '0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cnt      = 0;
        rst_n    = 0;
        in_valid = 0;
        flush    = 0;
        Re_in    = '0;
        Im_in    = '0;
        test_reset();
        test_ramp_flush();
        test_gaps();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_sdf_delay_stage.md
Name: fft_sdf_delay_stage

Overview:
- Single-path delay-feedback (SDF) controller and delay line for one radix-2 decimation-in-frequency FFT stage.
- Takes a serial complex sample stream and pairs sample n with sample n+D.
- Drives the combinational butterfly adder of the same stage and feeds its difference output back into the delay line.
- Emits the stage output stream (sums, then the delayed differences) with a twiddle index for the downstream twiddle multiplier.

Parameters:
- bit_width, 16, two's-complement width of every real/imag sample.
- delay_depth, 8, D = N/2 for this stage; must be a power of two, >= 2.
- addr_w, 3, log2(delay_depth).

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  Re_in/Im_in carry a sample this cycle.
- flush  in  1  drain stored differences with zero input.
- Re_in  in  bit_width  input sample, real.
- Im_in  in  bit_width  input sample, imag.
- bf_en  out  1  enable to butterfly adder (combinational).
- bf_Re_a  out  bit_width  delayed sample to adder (combinational).
- bf_Im_a  out  bit_width  delayed sample to adder (combinational).
- bf_Re_b  out  bit_width  current sample to adder (combinational).
- bf_Im_b  out  bit_width  current sample to adder (combinational).
- bf_Re_sum  in  bit_width  adder a+b, real.
- bf_Im_sum  in  bit_width  adder a+b, imag.
- bf_Re_diff  in  bit_width  adder a-b, real.
- bf_Im_diff  in  bit_width  adder a-b, imag.
- out_valid  out  1  registered output strobe.
- Re_out  out  bit_width  registered output sample, real.
- Im_out  out  bit_width  registered output sample, imag.
- tw_idx  out  addr_w  twiddle index k; 0 for sum outputs.

Behaviour:
- adv = in_valid | (flush & primed & phase==FILL). When flush advances without in_valid, the input is forced to 0. Both cases count as advances.
- State: phase in {FILL, BFLY}; ptr counts 0..D-1; primed flag; delay RAM of D complex words.
- Every adv:
  - ptr increments.
  - When ptr wraps D-1 -> 0, phase toggles.
  - primed sets on the first FILL->BFLY toggle.
- No adv: all state holds and out_valid = 0 next cycle. Gaps are allowed anywhere.
- FILL, on adv:
  - ram[ptr] <= input.
  - If primed: registered output <= ram[ptr] (old value, read-before-write), tw_idx <= ptr, out_valid <= 1.
  - If not primed: out_valid <= 0.
- BFLY:
  - bf_en = adv.
  - bf_a = ram[ptr], bf_b = input.
  - On adv: ram[ptr] <= diff, output <= sum, tw_idx <= 0, out_valid <= 1.
- bf_* outputs are combinational. bf_en = 0 outside BFLY or without adv, and bf_a/bf_b hold their values then.
- Latency: sum of pair (n, n+D) appears 1 clk after sample n+D is accepted. diff k appears 1 clk after the FILL advance at ptr=k of the next block.
- Output order per block: D sums, then D diffs. The diffs are delayed by one half-block, giving the standard SDF output order.
- Arithmetic: the adder wraps modulo 2^bit_width. This block performs no extra growth handling, except under the optional feature below.
- flush:
  - Ignored while in BFLY or while not primed.
  - After D flush advances the last diffs have drained, the phase is BFLY, and flush has no further effect.
  - in_valid and flush together: in_valid wins and the real input is used.
- Reset (async, any time including mid-block):
  - ptr = 0, phase = FILL, primed = 0, out_valid = 0, Re_out = Im_out = 0, tw_idx = 0.
  - RAM is not cleared; primed = 0 masks stale contents.

Optional Feature:
- SDF_SCALE_EN
  - Defined: sum and diff are each arithmetic-shifted right by 1 with round-half-up before output/RAM write. Rounding is (x + 1) >>> 1 computed at bit_width+1, then truncated. Prevents stage growth.
  - Undefined: values pass unmodified.
  - Flush and FILL paths are unaffected in both cases.

Test Plan:
- D=4, continuous input x=1..8 (imag 0) -> sums 6,8,10,12 on cycles after x=5..8 with tw_idx 0; out_valid low during the first 4 inputs.
- Same stream followed by flush for 4 clk -> outputs diffs -4,-4,-4,-4 with tw_idx 0,1,2,3; after that, flush produces no out_valid.
- in_valid toggling 1,0,1,0 over two blocks -> same values and order as the continuous case; out_valid never high on a cycle following an idle cycle.
- Reset pulse during BFLY at ptr=2 -> out_valid/Re_out/Im_out/tw_idx are 0 immediately; the next 4 inputs produce no output (unprimed).
- Re = 32767 paired with 32767 -> without the macro the sum wraps to -2; with SDF_SCALE_EN the sum outputs 32767 and the diff 0.
- Back-to-back blocks -> diffs of block k are interleaved exactly D cycles before the sums of block k+1; bf_en is high only during BFLY advances.
